multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Parametrised multicycle MIPS main control unit, next generation of the mux-only `Control` block. Holds the instruction-sequencing state machine and drives every datapath select (RegDst, IorD, MemtoReg, ALUSrcA, ALUSrcB, PCSource), the write strobes, and a stall-capable memory handshake. Sits between the instruction register's opcode field and the existing datapath muxes. Supports lw, sw, R-type, beq, j and addi, and traps illegal opcodes.

## Interface
- `OP_W`, 6: opcode width; must be ≥ 6.
- `MEM_HANDSHAKE`, 1: 1 means memory states wait for `mem_ready`; 0 means memory always completes in one cycle and `mem_ready` is ignored.
- `OP_LW`/`OP_SW`/`OP_R`/`OP_BEQ`/`OP_J`/`OP_ADDI`, 6'h23/6'h2B/6'h00/6'h04/6'h02/6'h08: opcode encodings, zero-extended to `OP_W`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in OP_W: opcode from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access complete.
- `reg_dst`, `ior_d`, `mem_to_reg`, `alu_src_a` out 1: mux selects.
- `alu_src_b` out 2: 00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- `pc_source` out 2: 00=ALUResult, 01=ALUOut, 10=jump target.
- `alu_op` out 2: 00=add, 01=sub, 10=funct-decoded.
- `ir_write`, `reg_write`, `mem_read`, `mem_write`, `pc_en` out 1: strobes.
- `illegal` out 1: sticky illegal-opcode flag.
- `state_o` out 4: current state encoding, for debug only.

## Operation
- States:
  - FETCH(0): mem_read, ALUSrcA=0, ALUSrcB=01, alu_op=00, pc_source=00, ior_d=0. ir_write and pc_en pulse on completion.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, alu_op=00.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, alu_op=00.
  - MEMRD(3): mem_read, ior_d=1.
  - MEMWB(4): reg_write, reg_dst=0, mem_to_reg=1.
  - MEMWR(5): mem_write, ior_d=1.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, alu_op=10.
  - RWB(7): reg_write, reg_dst=1, mem_to_reg=0.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, alu_op=01, pc_source=01. pc_en = `zero`.
  - JUMP(9): pc_source=10, pc_en=1.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, alu_op=00.
  - ADDIWB(11): reg_write, reg_dst=0, mem_to_reg=0.
  - ILLEGAL(12): no strobes, `illegal`=1.
- Transitions:
  - FETCH→DECODE on completion.
  - DECODE→MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), ADDIEX (addi), ILLEGAL (other).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB on completion; MEMWR→FETCH on completion.
  - EXEC→RWB; ADDIEX→ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP→FETCH.
  - ILLEGAL is absorbing until reset.
- Completion of FETCH, MEMRD and MEMWR is `mem_ready`=1 when MEM_HANDSHAKE=1, else unconditional.
- Select outputs not listed for a state are 0. Strobes not listed are 0.
- `op` is sampled only in DECODE and MEMADR. Changes to `op` in any other state have no effect.

## Timing
- Mux selects and `alu_op` are Moore outputs decoded from the registered state.
- ir_write, pc_en in FETCH, and pc_en in BRANCH are Mealy outputs: they are gated combinationally by `mem_ready` and `zero`, in the same cycle.
- mem_read/mem_write stay high for every cycle of a waiting memory state.
- Cycles per instruction with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each wait cycle adds 1.
- Reset:
  - While `reset`=1, all strobes are forced to 0.
  - On the first edge with reset high, the state becomes FETCH and `illegal` becomes 0.
  - After release, FETCH select values appear immediately. mem_read=1 in the first cycle after release.
- Reset mid-instruction aborts the instruction at the next edge. No partial strobes are issued in that cycle.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit);
  - the default opcode constants;
  - the ALUSrcB, PCSource and ALUOp encodings.
- Sub-module `control_decode` is purely combinational: state + mem_ready + zero → all outputs.
- The top level holds the state register, the next-state logic and the `illegal` flop.

## Test plan
- MEM_HANDSHAKE=0, op=0x23 → state sequence 0,1,2,3,4,0 over 5 cycles. reg_write=1 and mem_to_reg=1 only in cycle 5.
- MEM_HANDSHAKE=1, mem_ready held low for 3 cycles in FETCH → mem_read=1 for 4 cycles. ir_write and pc_en pulse exactly once, in the mem_ready cycle.
- op=0x04 with zero=1, then with zero=0 → pc_en=1 in BRANCH for the first case and 0 for the second. pc_source=01 in both; 3 cycles each.
- op=0x3F → ILLEGAL reached after DECODE. illegal=1 and no strobes for 10+ cycles. reset clears illegal and returns to FETCH.
- reset asserted in MEMWR with mem_ready=1 → mem_write=0 that cycle, state=FETCH next cycle.
- Back-to-back R, addi, j, sw → reg_dst 1/0, alu_src_b 00/10, pc_source=10 in JUMP. Totals 4+4+3+4 cycles.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// mips_ctrl_pkg: shared types for the multicycle MIPS main control unit.
// Contents: 4-bit state enum, default 6-bit opcode constants, datapath select
// encodings (ALUSrcB, PCSource, ALUOp) and the packed control-word struct that
// carries every decoded output from control_decode to the top level.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRwb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StIllegal = 4'd12
  } state_e;

  localparam logic [5:0] OpcLw   = 6'h23;
  localparam logic [5:0] OpcSw   = 6'h2B;
  localparam logic [5:0] OpcR    = 6'h00;
  localparam logic [5:0] OpcBeq  = 6'h04;
  localparam logic [5:0] OpcJ    = 6'h02;
  localparam logic [5:0] OpcAddi = 6'h08;

  typedef enum logic [1:0] {
    SrcBReg   = 2'b00,
    SrcBFour  = 2'b01,
    SrcBImm   = 2'b10,
    SrcBImmSh = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PcAluResult = 2'b00,
    PcAluOut    = 2'b01,
    PcJump      = 2'b10
  } pc_source_e;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic       reg_dst;
    logic       ior_d;
    logic       mem_to_reg;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    pc_source_e pc_source;
    alu_op_e    alu_op;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_en;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: bundle between the control unit and the datapath.
// Inputs to control: op, zero, mem_ready. Outputs from control: mux selects
// (reg_dst, ior_d, mem_to_reg, alu_src_a, alu_src_b, pc_source), alu_op,
// strobes (ir_write, reg_write, mem_read, mem_write, pc_en), illegal, state_o.
// Modport master = control unit, slave = datapath.
interface multicycle_control_fsm_if #(
  parameter int unsigned OP_W = 6
);
  logic [OP_W-1:0] op;
  logic            zero;
  logic            mem_ready;

  logic            reg_dst;
  logic            ior_d;
  logic            mem_to_reg;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [1:0]      pc_source;
  logic [1:0]      alu_op;
  logic            ir_write;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            pc_en;
  logic            illegal;
  logic [3:0]      state_o;

  modport master (
    input  op, zero, mem_ready,
    output reg_dst, ior_d, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
    output ir_write, reg_write, mem_read, mem_write, pc_en, illegal, state_o
  );

  modport slave (
    output op, zero, mem_ready,
    input  reg_dst, ior_d, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op,
    input  ir_write, reg_write, mem_read, mem_write, pc_en, illegal, state_o
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// control_decode: purely combinational output decoder.
// Ports: state (current FSM state), mem_ready (memory handshake), zero (ALU
// flag) -> ctrl (every select, alu_op and strobe). Selects are Moore; the
// FETCH ir_write/pc_en and BRANCH pc_en are gated by mem_ready/zero in-cycle.
module control_decode
  import mips_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  logic mem_done;
  assign mem_done = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.ir_write  = mem_done;
        ctrl.pc_en     = mem_done;
      end
      StDecode: ctrl.alu_src_b = SrcBImmSh;
      StMemAdr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      StExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluFunct;
      end
      StRwb: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = AluSub;
        ctrl.pc_source = PcAluOut;
        ctrl.pc_en     = zero;
      end
      StJump: begin
        ctrl.pc_source = PcJump;
        ctrl.pc_en     = 1'b1;
      end
      StAddiEx: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
      end
      StAddiWb: ctrl.reg_write = 1'b1;
      default: ctrl = '0;  // ILLEGAL and unused codes drive nothing
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multicycle MIPS main control unit (lw, sw, R, beq,
// j, addi; other opcodes trap into an absorbing ILLEGAL state).
// Ports: clk, reset (synchronous, active-high), bus (master modport of
// multicycle_control_fsm_if carrying op/zero/mem_ready in and all selects,
// strobes, illegal and state_o out).
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned     OP_W          = 6,
  parameter bit              MEM_HANDSHAKE = 1'b1,
  parameter logic [OP_W-1:0] OP_LW         = OP_W'(OpcLw),
  parameter logic [OP_W-1:0] OP_SW         = OP_W'(OpcSw),
  parameter logic [OP_W-1:0] OP_R          = OP_W'(OpcR),
  parameter logic [OP_W-1:0] OP_BEQ        = OP_W'(OpcBeq),
  parameter logic [OP_W-1:0] OP_J          = OP_W'(OpcJ),
  parameter logic [OP_W-1:0] OP_ADDI       = OP_W'(OpcAddi)
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_control_fsm_if.master bus
);

  if (OP_W < 6) begin : gen_op_w_check
    $error("OP_W must be at least 6");
  end

  state_e state_q, state_d;
  logic   illegal_q;
  logic   mem_done;
  ctrl_t  ctrl;

  assign mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

  // op is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (mem_done) state_d = StDecode;
      StDecode: begin
        if (bus.op == OP_LW || bus.op == OP_SW) state_d = StMemAdr;
        else if (bus.op == OP_R)                state_d = StExec;
        else if (bus.op == OP_BEQ)              state_d = StBranch;
        else if (bus.op == OP_J)                state_d = StJump;
        else if (bus.op == OP_ADDI)             state_d = StAddiEx;
        else                                    state_d = StIllegal;
      end
      StMemAdr: state_d = (bus.op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  if (mem_done) state_d = StMemWb;
      StMemWr:  if (mem_done) state_d = StFetch;
      StExec:   state_d = StRwb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StRwb, StAddiWb, StBranch, StJump: state_d = StFetch;
      StIllegal: state_d = StIllegal;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StIllegal) illegal_q <= 1'b1;
    end
  end

  control_decode #(
    .MEM_HANDSHAKE(MEM_HANDSHAKE)
  ) u_decode (
    .state    (state_q),
    .mem_ready(bus.mem_ready),
    .zero     (bus.zero),
    .ctrl     (ctrl)
  );

  assign bus.reg_dst    = ctrl.reg_dst;
  assign bus.ior_d      = ctrl.ior_d;
  assign bus.mem_to_reg = ctrl.mem_to_reg;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.pc_source  = ctrl.pc_source;
  assign bus.alu_op     = ctrl.alu_op;

  // Strobes are killed during reset so an aborted instruction leaves no trace.
  assign bus.ir_write  = ctrl.ir_write  & ~reset;
  assign bus.reg_write = ctrl.reg_write & ~reset;
  assign bus.mem_read  = ctrl.mem_read  & ~reset;
  assign bus.mem_write = ctrl.mem_write & ~reset;
  assign bus.pc_en     = ctrl.pc_en     & ~reset;

  assign bus.illegal = illegal_q;
  assign bus.state_o = state_q;

endmodule
